// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the FIFO-buffered UART transmitter.
// Holds the FSM state enum, the frame-length and parity encodings, the
// minimum bit-time divisor and small helpers that decode the frame length.
package uart_tx_fifo_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DB5 = 2'b00,
    DB6 = 2'b01,
    DB7 = 2'b10,
    DB8 = 2'b11
  } data_bits_t;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_t;

  // Keeps only the bits that belong to the selected frame length.
  function automatic logic [7:0] data_mask(input logic [1:0] db);
    case (data_bits_t'(db))
      DB5:     data_mask = 8'h1F;
      DB6:     data_mask = 8'h3F;
      DB7:     data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  endfunction

  // Index of the last data bit: 5..8 bits map onto 4..7.
  function automatic logic [2:0] last_bit(input logic [1:0] db);
    last_bit = {1'b1, db};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO used as the transmit byte queue.
// Ports: clk, rst (sync, active-high), push/wdata write side, pop/rdata read
// side (rdata is the head entry, valid whenever empty is low), full, empty,
// count (entries held). A push while full is accepted only with a pop.
module uart_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Ports: clk, rst (sync, active-high); data_in/tx_en enqueue a byte;
// data_bits, parity_mode, stop2, baud_div configure each frame and are
// captured when the byte is popped; tx serial line (idle high), busy,
// done (one pulse per frame), fifo_full, fifo_empty, overflow (dropped write).
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             tx_en,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow
);

  import uart_tx_fifo_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       head;
  logic             full_w;
  logic             empty_w;
  logic [CW-1:0]    count;
  logic             pop;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       sh;
  logic [2:0]       bit_idx;
  logic [2:0]       last_q;
  logic             par_en_q;
  logic             par_q;
  logic             stop2_q;
  logic             extra_stop;

  logic [DIV_W-1:0] eff_div;
  logic [7:0]       load_data;
  logic             load_par;
  logic             load_par_en;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_en),
    .pop   (pop),
    .wdata (data_in),
    .rdata (head),
    .full  (full_w),
    .empty (empty_w),
    .count (count)
  );

  assign fifo_full  = full_w;
  assign fifo_empty = empty_w;

  // Frame parameters captured at a pop.
  assign eff_div     = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign load_data   = head & data_mask(data_bits);
  assign load_par    = (^load_data) ^ (parity_mode == PAR_ODD);
  assign load_par_en = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);

  // Pop in IDLE, or on the last cycle of the final stop bit for gapless frames.
  assign pop = !rst && (count != '0) &&
               ((state == IDLE) || ((state == STOP) && (cnt == '0) && !extra_stop));

  always_ff @(posedge clk) begin
    done     <= 1'b0;
    overflow <= tx_en && full_w && !pop;
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      cnt        <= '0;
      div_q      <= DIV_W'(MIN_DIV);
      sh         <= '0;
      bit_idx    <= '0;
      last_q     <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      extra_stop <= 1'b0;
    end else begin
      if (pop) begin
        state    <= START;
        tx       <= 1'b0;
        busy     <= 1'b1;
        cnt      <= eff_div - DIV_W'(1);
        div_q    <= eff_div;
        sh       <= load_data;
        last_q   <= last_bit(data_bits);
        par_en_q <= load_par_en;
        par_q    <= load_par;
        stop2_q  <= stop2;
      end else begin
        case (state)
          IDLE: begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
          START: begin
            if (cnt == '0) begin
              state   <= DATA;
              cnt     <= div_q - DIV_W'(1);
              tx      <= sh[0];
              bit_idx <= '0;
            end else begin
              cnt <= cnt - DIV_W'(1);
            end
          end
          DATA: begin
            if (cnt == '0) begin
              cnt <= div_q - DIV_W'(1);
              if (bit_idx == last_q) begin
                if (par_en_q) begin
                  state <= PARITY;
                  tx    <= par_q;
                end else begin
                  state      <= STOP;
                  tx         <= 1'b1;
                  extra_stop <= stop2_q;
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
                sh      <= sh >> 1;
                tx      <= sh[1];
              end
            end else begin
              cnt <= cnt - DIV_W'(1);
            end
          end
          PARITY: begin
            if (cnt == '0) begin
              state      <= STOP;
              tx         <= 1'b1;
              cnt        <= div_q - DIV_W'(1);
              extra_stop <= stop2_q;
            end else begin
              cnt <= cnt - DIV_W'(1);
            end
          end
          STOP: begin
            if (cnt == '0) begin
              if (extra_stop) begin
                extra_stop <= 1'b0;
                cnt        <= div_q - DIV_W'(1);
              end else begin
                // A non-empty FIFO is handled by the pop branch above.
                done  <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
                tx    <= 1'b1;
              end
            end else begin
              cnt <= cnt - DIV_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
        if (pop == 1'b0 && state == STOP && cnt == '0 && !extra_stop) done <= 1'b1;
      end
      // done also pulses when the end of a frame coincides with the next pop.
      if (pop && state == STOP) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios plus randomized frames,
// each compared cycle by cycle against a line waveform built from frame rules.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        tx_en;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [15:0] baud_div;
  logic        tx;
  logic        busy;
  logic        done;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  bit wave[$];

  uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .tx_en       (tx_en),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .baud_div    (baud_div),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Append the expected line levels of one frame, one entry per clock cycle.
  function automatic void add_frame(input logic [7:0] d, input int db, input int pm,
                                    input int s2, input int div);
    int n    = db + 5;
    int ones = 0;
    int eff  = (div < 2) ? 2 : div;
    bit pb;
    repeat (eff) wave.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (d[i]) ones++;
      repeat (eff) wave.push_back(d[i]);
    end
    if (pm == 1 || pm == 2) begin
      pb = ((ones % 2) == 1);
      if (pm == 2) pb = !pb;
      repeat (eff) wave.push_back(pb);
    end
    repeat ((s2 != 0 ? 2 : 1) * eff) wave.push_back(1'b1);
  endfunction

  task automatic write_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      data_in = b[i];
      tx_en   = 1'b1;
      step();
    end
    tx_en = 1'b0;
  endtask

  // Called right after the first write is driven; walks the expected waveform.
  task automatic check_wave(input int exp_done, input int exp_ovf, input string name);
    int d = 0;
    int o = 0;
    step();
    o += int'(overflow);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s latency: tx=%b busy=%b, want tx=1 busy=0", name, tx, busy);
    end
    foreach (wave[i]) begin
      step();
      d += int'(done);
      o += int'(overflow);
      vectors++;
      if (tx !== wave[i] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b, want tx=%b busy=1", name, i, tx, busy, wave[i]);
      end
    end
    step();
    d += int'(done);
    o += int'(overflow);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL %s end: tx=%b busy=%b empty=%b, want 1 0 1", name, tx, busy, fifo_empty);
    end
    vectors++;
    if (d != exp_done) begin
      miscompares++;
      $display("FAIL %s done count: got %0d want %0d", name, d, exp_done);
    end
    vectors++;
    if (o != exp_ovf) begin
      miscompares++;
      $display("FAIL %s overflow count: got %0d want %0d", name, o, exp_ovf);
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: tx=%b busy=%b done=%b ovf=%b, want 1 0 0 0", tx, busy, done, overflow);
    end
    vectors++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset flags: empty=%b full=%b, want 1 0", fifo_empty, fifo_full);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_8n1();
    logic [7:0] q[$];
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0; baud_div = 16'd4;
    wave.delete();
    add_frame(8'hA5, 3, 0, 0, 4);
    q = '{8'hA5};
    fork
      write_bytes(q);
      check_wave(1, 0, "8n1_a5");
    join
  endtask

  task automatic test_7e2();
    logic [7:0] q[$];
    data_bits = 2'b10; parity_mode = 2'b01; stop2 = 1'b1; baud_div = 16'd3;
    wave.delete();
    add_frame(8'h35, 2, 1, 1, 3);
    q = '{8'h35};
    fork
      write_bytes(q);
      check_wave(1, 0, "7e2_35");
    join
  endtask

  task automatic test_5o1();
    logic [7:0] q[$];
    data_bits = 2'b00; parity_mode = 2'b10; stop2 = 1'b0; baud_div = 16'd2;
    wave.delete();
    add_frame(8'h1F, 0, 2, 0, 2);
    q = '{8'h1F};
    fork
      write_bytes(q);
      check_wave(1, 0, "5o1_1f");
    join
    baud_div = 16'd1;
    wave.delete();
    add_frame(8'h00, 0, 2, 0, 1);
    q = '{8'h00};
    fork
      write_bytes(q);
      check_wave(1, 0, "5o1_00");
    join
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0; baud_div = 16'd2;
    wave.delete();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) add_frame(q[i], 3, 0, 0, 2);
    fork
      begin
        write_bytes(q);
        vectors++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1 || fifo_empty !== 1'b0) begin
          miscompares++;
          $display("FAIL overflow flags: full=%b ovf=%b empty=%b, want 1 1 0", fifo_full, overflow, fifo_empty);
        end
      end
      check_wave(5, 1, "back_to_back");
    join
  endtask

  task automatic test_cfg_change();
    logic [7:0] q[$];
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0; baud_div = 16'd4;
    wave.delete();
    q = '{8'($urandom), 8'($urandom)};
    add_frame(q[0], 3, 0, 0, 4);
    add_frame(q[1], 0, 0, 0, 4);
    fork
      begin
        write_bytes(q);
        repeat (7) step();
        data_bits = 2'b00;
      end
      check_wave(2, 0, "cfg_change");
    join
  endtask

  task automatic test_mid_reset();
    logic [7:0] q[$];
    int bad = 0;
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0; baud_div = 16'd4;
    q = '{8'h00, 8'h5A, 8'hC3};
    write_bytes(q);
    repeat (6) step();
    vectors++;
    if (fifo_empty !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: empty=%b busy=%b, want 0 1", fifo_empty, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: tx=%b busy=%b empty=%b done=%b, want 1 0 1 0", tx, busy, fifo_empty, done);
    end
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL after_reset: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int db, pm, s2, div, n;
    for (int it = 0; it < 8; it++) begin
      db  = int'($urandom_range(0, 3));
      pm  = int'($urandom_range(0, 3));
      s2  = int'($urandom_range(0, 1));
      div = int'($urandom_range(0, 5));
      n   = int'($urandom_range(1, 3));
      data_bits   = 2'(db);
      parity_mode = 2'(pm);
      stop2       = 1'(s2);
      baud_div    = 16'(div);
      wave.delete();
      q.delete();
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        add_frame(q[i], db, pm, s2, div);
      end
      fork
        write_bytes(q);
        check_wave(n, 0, $sformatf("random_%0d", it));
      join
    end
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; data_in = 8'h00;
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0; baud_div = 16'd4;
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_overflow();
    test_cfg_change();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning entries in the transmit FIFO (power of two, 2..64).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the baud divisor input.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  8  byte to enqueue; bits above the selected length ignored.
REQ-006 SHALL have port tx_en  input  1  write strobe; one byte enqueued per high cycle.
REQ-007 SHALL have port data_bits  input  2  frame length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-008 SHALL have port parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-009 SHALL have port stop2  input  1  0=one stop bit, 1=two stop bits.
REQ-010 SHALL have port baud_div  input  DIV_W  clock cycles per bit; values 0 and 1 treated as 2.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse per completed frame.
REQ-014 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-015 SHALL have port fifo_empty  output  1  FIFO holds zero entries.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE SHALL drive tx=1; if FIFO non-empty, SHALL pop one byte and latch data_bits, parity_mode, stop2 and the effective baud_div, then enter START.
REQ-019 Config inputs SHALL only be sampled at a pop; changes mid-frame SHALL NOT affect the current frame.
REQ-020 Latency: tx_en at cycle N into an empty FIFO with FSM in IDLE SHALL give tx=0 from cycle N+2.
REQ-021 START SHALL drive tx=0 for exactly baud_div cycles.
REQ-022 DATA SHALL send LSB first, each bit for baud_div cycles, for the latched length.
REQ-023 PARITY SHALL be entered only when parity is enabled; it SHALL drive XOR of the sent data bits (even) or its inverse (odd) for baud_div cycles.
REQ-024 STOP SHALL drive tx=1 for baud_div cycles (one stop bit) or 2*baud_div cycles (two stop bits).
REQ-025 At the end of STOP, done SHALL pulse for one cycle.
REQ-026 At the end of STOP with the FIFO non-empty, the FSM SHALL pop and enter START in the next cycle with no idle bit time, and busy SHALL stay high.
REQ-027 At the end of STOP with the FIFO empty, the FSM SHALL return to IDLE.
REQ-028 busy SHALL be high from the cycle after a pop through the last stop-bit cycle, and low in IDLE.
REQ-029 A write while full without a simultaneous pop SHALL be dropped, pulse overflow, and leave FIFO contents unchanged.
REQ-030 A write while full with a simultaneous pop SHALL be accepted; the count stays at FIFO_DEPTH.
REQ-031 A simultaneous write and pop on a non-full FIFO SHALL leave the count unchanged and preserve order.
REQ-032 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 The bit-time counter SHALL be DIV_W bits wide and SHALL never overflow for any legal baud_div.

Reset
REQ-034 While rst is high: tx=1, busy=0, done=0, overflow=0, fifo_empty=1, fifo_full=0, FSM=IDLE, FIFO pointers and count=0.
REQ-035 Reset mid-frame SHALL abort the frame immediately (tx=1 on the next cycle), discard all queued bytes, and emit no done pulse.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the data_bits and parity_mode encodings, and the minimum-divisor constant (2).
REQ-037 The FIFO SHALL be one sub-module, uart_sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/count); the FSM, counters and shifter SHALL stay in the top module.

Verification
REQ-038 Scenario 1: baud_div=4, 8N1, write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; start at N+2; done pulses once; busy low after.
REQ-039 Scenario 2: baud_div=3, 7E2, write 0x35 -> 7 data bits 1,0,1,0,1,1,0, then parity 0, then stop high for 6 cycles.
REQ-040 Scenario 3: 5O1, write 0x1F -> parity bit 0; write 0x00 -> parity bit 1.
REQ-041 Scenario 4: FIFO_DEPTH=4, write 6 bytes back-to-back while busy -> first byte pops and 4 are stored, so exactly one overflow pulse at the 6th write; the 5 accepted bytes go out with no idle gap; 5 done pulses.
REQ-042 Scenario 5: change data_bits from 8 to 5 during DATA of frame 1 -> frame 1 stays 8 bits; frame 2 is 5 bits.
REQ-043 Scenario 6: rst during DATA with 2 bytes queued -> next cycle tx=1, busy=0, fifo_empty=1; no done pulse; no further frames.
